// File: rtl/fifo_reader_pkg.sv
// Shared constants and helpers for the synchronous-FIFO stream reader.
package fifo_reader_pkg;

  localparam int FIFO_RD_LATENCY  = 1;
  localparam int READER_BUF_DEPTH = 2;

  // Bits needed to count 0..value-1; never less than 1.
  function automatic int clogb2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/sync_fifo_stream_reader_buf.sv
// stream_buf2: two-entry ordered buffer; head is the oldest word, tail the next.
module stream_buf2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] tail_q;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      head   <= '0;
      tail_q <= '0;
      occ    <= 2'd0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail_q <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail_q;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the incoming word lands behind whatever remains.
          if (occ == 2'd2) begin
            head   <= tail_q;
            tail_q <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Read-side consumer for sync_fifo: credit-based rd_en, latency absorption, valid/ready output.
// Optional packet framing on m_last_o is enabled by defining FIFO_READER_LAST_EN.
module sync_fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [1:0]            occupancy_o
);

  if (FIFO_RD_LATENCY != 1 || PKT_LEN < 2 || PKT_LEN > 65536) begin : g_bad_cfg
    $error("sync_fifo_stream_reader: unsupported FIFO latency or PKT_LEN");
  end

  logic       empty_q;
  logic       inflight;
  logic       drop;
  logic [1:0] occ;
  logic       pop;
  logic       capture;
  logic [2:0] credit;

  // Handshake: a beat transfers on a clock edge where m_valid_o & m_ready_i; while
  // m_valid_o is high and m_ready_i low the word is held. A flush cycle voids the transfer.
  assign pop     = m_valid_o & m_ready_i & ~flush_i;
  assign capture = inflight & ~drop;

  // Words already owed to the buffer (held + arriving) minus the one leaving now.
  assign credit       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en_o = ~empty_q & ~flush_i & ~rst_i & (credit < 3'(READER_BUF_DEPTH));

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      empty_q  <= 1'b1;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      empty_q  <= fifo_empty_i;
      inflight <= fifo_rd_en_o;
      drop     <= flush_i & inflight;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .sys_clk_i(sys_clk_i),
    .rst_i    (rst_i),
    .clear    (flush_i),
    .push     (capture),
    .pop      (pop),
    .din      (fifo_dout_i),
    .head     (m_data_o),
    .occ      (occ)
  );

  assign m_valid_o   = (occ != 2'd0);
  assign occupancy_o = occ;

`ifdef FIFO_READER_LAST_EN
  localparam int CNT_W = clogb2(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [CNT_W-1:0] beat_q;

  // beat_q is the packet index of the word currently at the buffer head.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i || flush_i) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

  assign m_last_o = m_valid_o & (beat_q == LAST_BEAT);
`else
  assign m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader attached to a behavioural 16-deep sync_fifo with look-ahead empty.
module tb_sync_fifo_stream_reader;

  localparam int DW        = 8;
  localparam int PKT_LEN   = 4;
  localparam int FIFO_DEEP = 16;

  // ---------------- clock / reset ----------------
  logic sys_clk_i = 1'b0;
  logic rst_i;
  always #5 sys_clk_i = ~sys_clk_i;

  logic          flush_i;
  logic          m_ready_i;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic [1:0]    occupancy_o;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;

  sync_fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en),
    .fifo_dout_i (fifo_dout),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .occupancy_o (occupancy_o)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem [FIFO_DEEP];
  logic [3:0]    wr_ptr, rd_ptr;
  logic [4:0]    count;
  int            underflows = 0;
  int            cyc = 0;

  // Look-ahead empty: already reflects this cycle's read, not this cycle's write.
  assign fifo_empty = (count == 5'd0) || (count == 5'd1 && fifo_rd_en);

  always @(posedge sys_clk_i) begin
    cyc <= cyc + 1;
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_dout <= '0;
    end else begin
      if (fifo_wr_en) begin
        mem[wr_ptr] <= fifo_din;
        wr_ptr      <= wr_ptr + 4'd1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 4'd1;
        if (count == 5'd0) underflows <= underflows + 1;
      end
      count <= count + {4'd0, fifo_wr_en} - {4'd0, fifo_rd_en};
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int            beat_idx     = 0;
  int            pop_total    = 0;
  int            last_total   = 0;
  int            rd_total     = 0;
  int            last_pop_cyc = 0;
  int            lat_cyc      = 0;
  bit            lat_armed    = 0;
  bit            hold_prev    = 0;
  logic [DW-1:0] hold_data;

  initial begin
    logic [DW-1:0] exp_w;
    logic          exp_last;
    forever begin
      @(negedge sys_clk_i);
      if (fifo_rd_en) rd_total++;
      if (!rst_i && !flush_i) begin
        if (hold_prev) begin
          check("hold_valid", {31'd0, m_valid_o}, 32'd1);
          check("hold_data", {24'd0, m_data_o}, {24'd0, hold_data});
        end
        if (lat_armed && m_valid_o) begin
          lat_cyc   = cyc;
          lat_armed = 0;
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {24'd0, m_data_o}, 32'hFFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("data", {24'd0, m_data_o}, {24'd0, exp_w});
          end
`ifdef FIFO_READER_LAST_EN
          exp_last = (beat_idx == PKT_LEN - 1);
`else
          exp_last = 1'b0;
`endif
          check("last", {31'd0, m_last_o}, {31'd0, exp_last});
          if (m_last_o) last_total++;
          beat_idx     = (beat_idx == PKT_LEN - 1) ? 0 : beat_idx + 1;
          pop_total++;
          last_pop_cyc = cyc;
        end
        hold_prev = m_valid_o && !m_ready_i;
        hold_data = m_data_o;
      end else begin
        hold_prev = 0;
        beat_idx  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_wr_en = 1'b1;
    fifo_din   = w;
    exp_q.push_back(w);
    tick();
    fifo_wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    check({tag, "_valid"}, {31'd0, m_valid_o}, 32'd0);
    check({tag, "_data"}, {24'd0, m_data_o}, 32'd0);
    check({tag, "_last"}, {31'd0, m_last_o}, 32'd0);
    check({tag, "_occ"}, {30'd0, occupancy_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int wr_cyc, p0, r0, l0, gap;
    logic [DW-1:0] dropped;

    rst_i      = 1'b1;
    flush_i    = 1'b0;
    m_ready_i  = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) tick();

    // Back-to-back burst into an empty FIFO: latency and full throughput.
    m_ready_i = 1'b1;
    lat_armed = 1;
    wr_cyc    = cyc;
    p0        = pop_total;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    wait_drain(50);
    check("first_valid_latency", lat_cyc - wr_cyc, 4);
    check("burst_beats", pop_total - p0, 8);
    check("burst_span", last_pop_cyc - lat_cyc, 7);

    // Downstream stall: buffer fills to two, reads stop, data held.
    m_ready_i = 1'b0;
    for (int i = 0; i < 14; i++) push_word(8'h20 + DW'(i));
    repeat (4) tick();
    check("stall_fill_occ", {30'd0, occupancy_o}, 2);
    check("stall_fill_rd_idle", {31'd0, fifo_rd_en}, 0);
    m_ready_i = 1'b1;
    repeat (6) tick();
    m_ready_i = 1'b0;
    r0 = rd_total;
    repeat (5) tick();
    check("stall_reads", rd_total - r0, 0);
    check("stall_occ", {30'd0, occupancy_o}, 2);
    m_ready_i = 1'b1;
    wait_drain(60);

    // Trickle writes with random gaps and random backpressure.
    for (int i = 0; i < 30; i++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      push_word(8'h40 + DW'(i));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        m_ready_i = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    m_ready_i = 1'b1;
    wait_drain(80);

    // Flush in steady streaming: head word and in-flight word are discarded.
    m_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) push_word(8'h80 + DW'(i));
    repeat (4) tick();
    m_ready_i = 1'b1;
    repeat (3) tick();
    flush_i = 1'b1;
    dropped = exp_q.pop_front();
    dropped = exp_q.pop_front();
    tick();
    flush_i = 1'b0;
    check("flush_valid", {31'd0, m_valid_o}, 0);
    check("flush_occ", {30'd0, occupancy_o}, 0);
    check("flush_next_word", {24'd0, exp_q[0]}, {24'd0, dropped + 8'd1});
    wait_drain(60);

    // Packet framing over ten beats with random stalls.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    l0 = last_total;
    for (int i = 0; i < 10; i++) begin
      m_ready_i = ($urandom_range(0, 2) != 0);
      push_word(8'hC0 + DW'(i));
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      m_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    m_ready_i = 1'b1;
    wait_drain(40);
`ifdef FIFO_READER_LAST_EN
    check("last_count", last_total - l0, 2);
`else
    check("last_count", last_total - l0, 0);
`endif

    // Reset mid-stream together with the FIFO.
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'hE0 + DW'(i));
    m_ready_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b1;
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    check_reset_outputs("midreset");
    for (int i = 0; i < 5; i++) push_word(8'hF0 + DW'(i));
    wait_drain(40);

    check("underflow", underflows, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
